// File: rtl/fwd_hazard_unit_if.sv
// ID-stage instruction fields into the forwarding/hazard unit, and the
// forward selects, stall and stall counter it returns.
interface fwd_hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, flush,
        input  fa, fb, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, flush,
        output fa, fb, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for a 5-stage pipeline.
// Tracks ID/EX, EX/MEM and MEM/WB register usage; counts stall cycles.
module fwd_hazard_unit #(
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    fwd_hazard_unit_if.slave  bus
);

    // ID/EX tracking
    logic       ex_valid;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    // EX/MEM tracking
    logic       mem_valid;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    // MEM/WB tracking
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_regwrite;

    logic [CNT_W-1:0] cnt_q;
    logic             stall;
    logic             bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    // Newest producer (EX/MEM) wins over MEM/WB; r0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       r_valid,
        input logic [4:0] r,
        input logic       mv, input logic mw, input logic [4:0] md,
        input logic       wv, input logic ww, input logic [4:0] wd
    );
        if (!r_valid)                              return 2'b00;
        if (mv && mw && (md != 5'd0) && (md == r)) return 2'b10;
        if (wv && ww && (wd != 5'd0) && (wd == r)) return 2'b01;
        return 2'b00;
    endfunction

    assign stall = bus.id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) &&
                   ((ex_rd == bus.id_rs) || (ex_rd == bus.id_rt));
    assign bubble = bus.flush || stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rs        <= 5'd0;
            ex_rt        <= 5'd0;
            ex_rd        <= 5'd0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= 5'd0;
            mem_regwrite <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_regwrite  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_rs       <= 5'd0;
                ex_rt       <= 5'd0;
                ex_rd       <= 5'd0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end else begin
                ex_valid    <= bus.id_valid;
                ex_rs       <= bus.id_rs;
                ex_rt       <= bus.id_rt;
                ex_rd       <= bus.id_rd;
                ex_regwrite <= bus.id_regwrite;
                ex_memread  <= bus.id_memread;
            end
            // EX/MEM boundary
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            // MEM/WB boundary
            wb_valid     <= mem_valid;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            // A flushed slot would have been squashed anyway, so it is not a stall cycle.
            if (stall && !bus.flush)
                cnt_q <= sat_inc(cnt_q);
        end
    end

    assign bus.fa        = fwd_sel(ex_valid, ex_rs, mem_valid, mem_regwrite, mem_rd,
                                   wb_valid, wb_regwrite, wb_rd);
    assign bus.fb        = fwd_sel(ex_valid, ex_rt, mem_valid, mem_regwrite, mem_rd,
                                   wb_valid, wb_regwrite, wb_rd);
    assign bus.stall     = stall;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Table-driven bench for fwd_hazard_unit with an expected-output queue,
// plus a small-counter instance driven into saturation.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_s;

    fwd_hazard_unit_if #(.CNT_W(16)) bus ();
    fwd_hazard_unit_if #(.CNT_W(2))  sbus ();

    fwd_hazard_unit #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst),   .bus(bus));
    fwd_hazard_unit #(.CNT_W(2))  u_sat (.clk(clk), .rst(rst_s), .bus(sbus));

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic        rw, mr, fl;
        logic        chk;
        logic [1:0]  fa, fb;
        logic        st;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          tag;
        logic [1:0]  fa, fb;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic addv(input logic r, input logic v, input int rs, input int rt,
                        input int rd, input logic rw, input logic mr, input logic fl,
                        input logic chk, input int fa, input int fb, input logic st,
                        input int cnt);
        vec_t t;
        t.rst = r; t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
        t.rw = rw; t.mr = mr; t.fl = fl; t.chk = chk;
        t.fa = 2'(fa); t.fb = 2'(fb); t.st = st; t.cnt = 16'(cnt);
        tbl.push_back(t);
    endtask

    task automatic check(input string nm, input int tag, input logic [15:0] act,
                         input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step %0d: got %0d, expected %0d", nm, tag, act, req);
        end
    endtask

    task automatic drive(input vec_t t);
        rst              = t.rst;
        bus.id_valid     = t.v;
        bus.id_rs        = t.rs;
        bus.id_rt        = t.rt;
        bus.id_rd        = t.rd;
        bus.id_regwrite  = t.rw;
        bus.id_memread   = t.mr;
        bus.flush        = t.fl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t z;
        exp_t e;
        rst = 1'b1; rst_s = 1'b1;
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_regwrite = 0; bus.id_memread = 0; bus.flush = 0;
        sbus.id_valid = 0; sbus.id_rs = 0; sbus.id_rt = 0; sbus.id_rd = 0;
        sbus.id_regwrite = 0; sbus.id_memread = 0; sbus.flush = 0;

        //    rst v  rs rt rd rw mr fl chk fa fb st cnt
        addv(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // 0 reset
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);   // 1 post-reset idle
        addv(0, 1, 1, 2, 3, 1, 0, 0, 1,  0, 0, 0, 0);   // 2 add r3
        addv(0, 1, 3, 4, 6, 1, 0, 0, 1,  0, 0, 0, 0);   // 3 consumer rs=3
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0);   // 4 EX/MEM forward fa=10
        addv(0, 1, 0, 0, 5, 1, 0, 0, 1,  0, 0, 0, 0);   // 5 writer r5 (older)
        addv(0, 1, 0, 0, 5, 1, 0, 0, 1,  0, 0, 0, 0);   // 6 writer r5 (newer)
        addv(0, 1, 1, 5, 8, 1, 0, 0, 1,  0, 0, 0, 0);   // 7 consumer rt=5
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 0, 0);   // 8 both match: fb=10
        addv(0, 1, 0, 0, 5, 1, 0, 0, 1,  0, 0, 0, 0);   // 9 writer r5
        addv(0, 1, 0, 0, 9, 0, 0, 0, 1,  0, 0, 0, 0);   // 10 non-writer rd=9
        addv(0, 1, 2, 5,10, 1, 0, 0, 1,  0, 0, 0, 0);   // 11 consumer rt=5
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0);   // 12 MEM/WB forward fb=01
        addv(0, 1, 1, 0, 7, 1, 1, 0, 1,  0, 0, 0, 0);   // 13 lw r7
        addv(0, 1, 7, 2,11, 1, 0, 0, 1,  0, 0, 1, 0);   // 14 load-use stall
        addv(0, 1, 7, 2,11, 1, 0, 0, 1,  0, 0, 0, 1);   // 15 bubble in EX, held consumer
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1);   // 16 consumer gets fa=01
        addv(0, 1, 0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1);   // 17 writer rd=0
        addv(0, 1, 0, 0,12, 1, 0, 0, 1,  0, 0, 0, 1);   // 18 consumer rs=rt=0
        addv(0, 1, 0, 0, 0, 1, 1, 0, 1,  0, 0, 0, 1);   // 19 lw rd=0; r0 not forwarded
        addv(0, 1, 0, 0,13, 1, 0, 0, 1,  0, 0, 0, 1);   // 20 no stall on r0 load
        addv(0, 0, 0, 0,14, 1, 0, 0, 1,  0, 0, 0, 1);   // 21 invalid writer rd=14
        addv(0, 1,14,14,15, 1, 0, 0, 1,  0, 0, 0, 1);   // 22 consumer of r14
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1);   // 23 invalid producer: no forward
        addv(0, 1, 0, 0, 7, 1, 1, 0, 1,  0, 0, 0, 1);   // 24 lw r7
        addv(0, 1, 7, 0,16, 1, 0, 1, 1,  0, 0, 1, 1);   // 25 stall+flush together
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1);   // 26 bubble, count unchanged
        addv(0, 1, 0, 0,20, 1, 0, 0, 1,  0, 0, 0, 1);   // 27 writer r20
        addv(0, 1,20, 0,21, 1, 0, 0, 1,  0, 0, 0, 1);   // 28 writer r21
        addv(0, 1,21,20,22, 1, 0, 0, 1,  2, 0, 0, 1);   // 29 writer r22
        addv(1, 1,22,21,23, 1, 0, 0, 1,  2, 1, 0, 1);   // 30 reset with writers in flight
        addv(0, 1,22,21,24, 1, 0, 0, 1,  0, 0, 0, 0);   // 31 after reset
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);   // 32 pre-reset writers gone
        addv(0, 1, 0, 0, 9, 1, 1, 0, 1,  0, 0, 0, 0);   // 33 lw r9
        addv(0, 1, 0, 9,17, 1, 0, 0, 1,  0, 0, 1, 0);   // 34 stall on rt match
        addv(0, 1, 0, 9,17, 1, 0, 0, 1,  0, 0, 0, 1);   // 35 held consumer
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 1);   // 36 fb=01 from load

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            if (tbl[i].chk) begin
                e.tag = i; e.fa = tbl[i].fa; e.fb = tbl[i].fb;
                e.st = tbl[i].st; e.cnt = tbl[i].cnt;
                sb.push_back(e);
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check("fa",        e.tag, {14'd0, bus.fa}, {14'd0, e.fa});
                check("fb",        e.tag, {14'd0, bus.fb}, {14'd0, e.fb});
                check("stall",     e.tag, {15'd0, bus.stall}, {15'd0, e.st});
                check("stall_cnt", e.tag, bus.stall_cnt, e.cnt);
            end
        end
        z = tbl[0];
        z.rst = 1'b0;
        drive(z);

        // Small counter: a load reading its own destination stalls every other cycle.
        @(posedge clk); #1;
        rst_s = 1'b1;
        sbus.id_valid = 1; sbus.id_rs = 5'd7; sbus.id_rt = 5'd0; sbus.id_rd = 5'd7;
        sbus.id_regwrite = 1; sbus.id_memread = 1; sbus.flush = 0;
        @(posedge clk); #1;
        rst_s = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            int n;
            n = (i - 1) / 2;
            e.tag = 100 + i; e.fa = 0; e.fb = 0;
            e.st  = (i % 2 == 0);
            e.cnt = 16'((n > 3) ? 3 : n);
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check("sat_stall", e.tag, {15'd0, sbus.stall}, {15'd0, e.st});
            check("sat_cnt",   e.tag, {14'd0, sbus.stall_cnt}, e.cnt);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
